// File: rtl/mem_sched_pkg.sv
// -----------------------------------------------------------------------------
// mem_sched_pkg
// Shared types and constants for the single-target memory scheduler.
//   e_sched_state : arbitration FSM states (idle / transfer outstanding)
//   REQ_N64       : index of the fixed-priority N64 PI requester
//   STARVE_CNT_W  : width of the consecutive-priority-grant counter
// -----------------------------------------------------------------------------
package mem_sched_pkg;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } e_sched_state;

   localparam int REQ_N64      = 0;
   localparam int STARVE_CNT_W = 4;

endpackage : mem_sched_pkg

// File: rtl/mem_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder over the low requesters
// (indices 1..NUM_REQ-1). Index 0 of the mask is never selected.
// The search starts at i_ptr+1 and wraps within 1..NUM_REQ-1, so the
// requester named by i_ptr (the last low winner) is considered last.
// Ports:
//   i_elig  : eligibility mask, one bit per requester (bit 0 ignored)
//   i_ptr   : last low-requester winner (1..NUM_REQ-1)
//   o_found : at least one low requester is eligible
//   o_idx   : selected low requester (valid when o_found)
// -----------------------------------------------------------------------------
module rr_pick
   import mem_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_elig,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   always_comb begin
      int w_cand;
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = 1;
      for (int k = 1; k < NUM_REQ; k++) begin
         // Map step k onto the low range 1..NUM_REQ-1, starting just past i_ptr.
         w_cand = ((int'(i_ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
         if (!o_found && i_elig[w_cand]) begin
            o_found = 1'b1;
            o_idx   = IDX_W'(w_cand);
         end
      end
   end

endmodule : rr_pick

// File: rtl/mem_sched_rr.sv
// -----------------------------------------------------------------------------
// mem_sched_rr
// Single-target memory scheduler: shares one memory controller port among
// NUM_REQ requesters. Requester 0 (N64 PI) has fixed priority; requesters
// 1..NUM_REQ-1 share round-robin. A starvation guard hands the port to a
// pending low requester after STARVE_LIMIT consecutive priority grants,
// unless lock is asserted (lock reserves the target for the PI path).
//
// Optional build macro MEM_SCHED_STATS_EN adds per-requester 32-bit grant
// counters (stat_clear in, stat_grants out).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   lock                : only requester 0 may be granted while high
//   req_request/write   : per-requester request and write flag
//   req_wmask/address/wdata : packed per-requester payloads
//   req_ack             : per-requester ack, combinational from mem_ack
//   req_rdata           : controller read data, broadcast
//   mem_request         : registered controller request
//   mem_write/wmask/address/wdata : registered payload of the granted requester
//   mem_ack, mem_rdata  : controller handshake and read data
//   stat_clear, stat_grants : grant statistics (MEM_SCHED_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_sched_rr
   import mem_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 27,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       lock,
   input  logic [NUM_REQ-1:0]         req_request,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [DATA_W-1:0]          req_rdata,
   output logic                       mem_request,
   output logic                       mem_write,
   output logic [DATA_W/8-1:0]        mem_wmask,
   output logic [ADDR_W-1:0]          mem_address,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_ack,
   input  logic [DATA_W-1:0]          mem_rdata
`ifdef MEM_SCHED_STATS_EN
   ,
   input  logic                       stat_clear,
   output logic [NUM_REQ*32-1:0]      stat_grants
`endif
);

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MASK_W = DATA_W / 8;

   e_sched_state            r_state;
   logic [IDX_W-1:0]        r_grant_idx;
   logic                    r_grant_valid;
   logic [IDX_W-1:0]        r_rr_ptr;
   logic [STARVE_CNT_W-1:0] r_starve_cnt;

   logic [NUM_REQ-1:0]      w_elig;
   logic                    w_low_any;
   logic                    w_rr_found;
   logic [IDX_W-1:0]        w_rr_idx;
   logic                    w_at_limit;
   logic                    w_pick_n64;
   logic                    w_grant;
   logic [IDX_W-1:0]        w_win_idx;

   logic                    w_sel_write;
   logic [MASK_W-1:0]       w_sel_wmask;
   logic [ADDR_W-1:0]       w_sel_address;
   logic [DATA_W-1:0]       w_sel_wdata;

   // ---------------------------------------------------------------------------
   // Eligibility: lock masks every low requester, never the PI path.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_elig          = req_request & {NUM_REQ{~lock}};
      w_elig[REQ_N64] = req_request[REQ_N64];
   end

   assign w_low_any = |w_elig[NUM_REQ-1:1];

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_elig  (w_elig),
      .i_ptr   (r_rr_ptr),
      .o_found (w_rr_found),
      .o_idx   (w_rr_idx)
   );

   // The guard only bites when a low requester is actually eligible; with
   // lock high no low requester is eligible, so the PI path always wins.
   assign w_at_limit = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
   assign w_pick_n64 = w_elig[REQ_N64] && !(w_at_limit && w_low_any);
   assign w_grant    = w_elig[REQ_N64] || w_rr_found;
   assign w_win_idx  = w_pick_n64 ? IDX_W'(REQ_N64) : w_rr_idx;

   // ---------------------------------------------------------------------------
   // Payload mux for the current winner.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_sel_write   = 1'b0;
      w_sel_wmask   = '0;
      w_sel_address = '0;
      w_sel_wdata   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_idx == IDX_W'(i)) begin
            w_sel_write   = req_write[i];
            w_sel_wmask   = req_wmask[i*MASK_W +: MASK_W];
            w_sel_address = req_address[i*ADDR_W +: ADDR_W];
            w_sel_wdata   = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Arbitration FSM. The payload is captured on the grant edge and held for
   // the whole BUSY phase, so requester changes during BUSY are invisible.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
         r_starve_cnt  <= '0;
         mem_request   <= 1'b0;
         mem_write     <= 1'b0;
         mem_wmask     <= '0;
         mem_address   <= '0;
         mem_wdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  mem_write     <= w_sel_write;
                  mem_wmask     <= w_sel_wmask;
                  mem_address   <= w_sel_address;
                  mem_wdata     <= w_sel_wdata;
                  mem_request   <= 1'b1;
                  r_grant_idx   <= w_win_idx;
                  r_grant_valid <= 1'b1;
                  r_state       <= S_BUSY;
                  if (!w_pick_n64) begin
                     r_rr_ptr <= w_rr_idx;
                  end
               end
               // Count back-to-back PI grants only while someone low is waiting.
               if (w_grant && !w_pick_n64) begin
                  r_starve_cnt <= '0;
               end else if (!w_low_any) begin
                  r_starve_cnt <= '0;
               end else if (w_pick_n64 && (r_starve_cnt < STARVE_CNT_W'(STARVE_LIMIT))) begin
                  r_starve_cnt <= r_starve_cnt + 1'b1;
               end
            end
            S_BUSY: begin
               if (mem_ack) begin
                  mem_request   <= 1'b0;
                  r_grant_valid <= 1'b0;
                  r_state       <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Ack routing: an ack with no outstanding grant is dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ack[i] = mem_ack && r_grant_valid && (r_grant_idx == IDX_W'(i));
      end
   end

   assign req_rdata = mem_rdata;

`ifdef MEM_SCHED_STATS_EN
   // ---------------------------------------------------------------------------
   // Per-requester grant counters; a clear coinciding with a grant wins.
   // ---------------------------------------------------------------------------
   logic [31:0] r_stat [NUM_REQ];

   always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_stat[i] <= '0;
         end
      end else if ((r_state == S_IDLE) && w_grant) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
               r_stat[i] <= r_stat[i] + 32'd1;
            end
         end
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_grants[i*32 +: 32] = r_stat[i];
      end
   end
`endif

endmodule : mem_sched_rr

// File: tb/tb_mem_sched_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_sched_rr
// Directed bench for mem_sched_rr (NUM_REQ=4, ADDR_W=27, DATA_W=16,
// STARVE_LIMIT=4). Inputs change 1 ns after the rising edge; outputs are
// sampled there as well.
// -----------------------------------------------------------------------------
module tb_mem_sched_rr;

   localparam int NR = 4;
   localparam int AW = 27;
   localparam int DW = 16;
   localparam int MW = DW / 8;
   localparam int SL = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              lock;
   logic [NR-1:0]     req_request;
   logic [NR-1:0]     req_write;
   logic [NR*MW-1:0]  req_wmask;
   logic [NR*AW-1:0]  req_address;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     req_ack;
   logic [DW-1:0]     req_rdata;
   logic              mem_request;
   logic              mem_write;
   logic [MW-1:0]     mem_wmask;
   logic [AW-1:0]     mem_address;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ack;
   logic [DW-1:0]     mem_rdata;
`ifdef MEM_SCHED_STATS_EN
   logic              stat_clear;
   logic [NR*32-1:0]  stat_grants;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_sched_rr #(
      .NUM_REQ      (NR),
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .lock        (lock),
      .req_request (req_request),
      .req_write   (req_write),
      .req_wmask   (req_wmask),
      .req_address (req_address),
      .req_wdata   (req_wdata),
      .req_ack     (req_ack),
      .req_rdata   (req_rdata),
      .mem_request (mem_request),
      .mem_write   (mem_write),
      .mem_wmask   (mem_wmask),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
`ifdef MEM_SCHED_STATS_EN
      ,
      .stat_clear  (stat_clear),
      .stat_grants (stat_grants)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      lock        = 1'b0;
      req_request = '0;
      req_write   = '0;
      req_wmask   = '0;
      req_address = '0;
      req_wdata   = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
`ifdef MEM_SCHED_STATS_EN
      stat_clear  = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = w;
      req_wmask[i*MW +: MW] = '1;
      req_address[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_request[i]        = 1'b1;
   endtask

   // Controller model: ack 'lat' cycles after mem_request is seen high.
   // gidx = acked requester, -1 if none/timeout, 99 if more than one.
   task automatic serve(input int lat, output int gidx);
      int t;
      t    = 0;
      gidx = -1;
      while (mem_request !== 1'b1 && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (mem_request === 1'b1) begin
         repeat (lat - 1) begin
            @(posedge clk);
            #1;
         end
         mem_ack = 1'b1;
         #1;
         for (int i = 0; i < NR; i++) begin
            if (req_ack[i] === 1'b1) gidx = (gidx == -1) ? i : 99;
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int exp_rr [6];
      int exp_st [10];
      exp_rr = '{1, 2, 3, 1, 2, 3};
      exp_st = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

      // ---- reset state and stray ack -----------------------------------------
      do_reset();
      chk("rst_mem_request", 64'(mem_request), 64'd0);
      chk("rst_mem_write",   64'(mem_write),   64'd0);
      chk("rst_mem_address", 64'(mem_address), 64'd0);
      chk("rst_mem_wdata",   64'(mem_wdata),   64'd0);
      chk("rst_mem_wmask",   64'(mem_wmask),   64'd0);
      chk("rst_req_ack",     64'(req_ack),     64'd0);
      mem_ack = 1'b1;
      #1;
      chk("stray_ack_req_ack", 64'(req_ack), 64'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("stray_ack_mem_request", 64'(mem_request), 64'd0);

      // ---- single write from requester 1 -------------------------------------
      set_req(1, 1'b1, 27'h0001000, 16'hBEEF);
      mem_rdata = 16'h1234;
      #1;
      chk("wr_pre_request", 64'(mem_request), 64'd0);
      @(posedge clk);
      #1;
      chk("wr_request",  64'(mem_request), 64'd1);
      chk("wr_write",    64'(mem_write),   64'd1);
      chk("wr_address",  64'(mem_address), 64'h0001000);
      chk("wr_wdata",    64'(mem_wdata),   64'hBEEF);
      chk("wr_wmask",    64'(mem_wmask),   64'h3);
      req_address[AW +: AW] = 27'h7FFFFFF;
      @(posedge clk);
      #1;
      chk("wr_hold_address", 64'(mem_address), 64'h0001000);
      chk("wr_hold_request", 64'(mem_request), 64'd1);
      @(posedge clk);
      #1;
      mem_ack = 1'b1;
      #1;
      chk("wr_req_ack", 64'(req_ack),   64'b0010);
      chk("wr_rdata",   64'(req_rdata), 64'h1234);
      req_request[1] = 1'b0;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("wr_done_request", 64'(mem_request), 64'd0);
      chk("wr_done_req_ack", 64'(req_ack),     64'd0);

      // ---- request dropped after capture still issues -------------------------
      set_req(3, 1'b0, 27'h0000333, 16'h0000);
      @(posedge clk);
      #1;
      req_request[3] = 1'b0;
      chk("drop_request", 64'(mem_request), 64'd1);
      chk("drop_address", 64'(mem_address), 64'h0000333);
      chk("drop_write",   64'(mem_write),   64'd0);
      serve(3, g);
      chk("drop_grant", 64'(g), 64'd3);

      // ---- round robin among 1,2,3 -------------------------------------------
      do_reset();
      set_req(1, 1'b0, 27'h0000100, 16'h1111);
      set_req(2, 1'b0, 27'h0000200, 16'h2222);
      set_req(3, 1'b0, 27'h0000300, 16'h3333);
      for (int k = 0; k < 6; k++) begin
         serve(2, g);
         chk($sformatf("rr_order[%0d]", k), 64'(g), 64'(exp_rr[k]));
      end
      req_request = '0;

      // ---- starvation guard: 0 and 2 held ------------------------------------
      do_reset();
      set_req(0, 1'b0, 27'h0000000, 16'h0000);
      set_req(2, 1'b0, 27'h0000200, 16'h2222);
      for (int k = 0; k < 10; k++) begin
         serve(2, g);
         chk($sformatf("starve_order[%0d]", k), 64'(g), 64'(exp_st[k]));
      end
      req_request = '0;

      // ---- lock: only requester 0, guard overridden --------------------------
      do_reset();
      lock = 1'b1;
      set_req(0, 1'b0, 27'h0000000, 16'h0000);
      set_req(2, 1'b1, 27'h0000222, 16'hA5A5);
      for (int k = 0; k < 6; k++) begin
         serve(2, g);
         chk($sformatf("lock_order[%0d]", k), 64'(g), 64'd0);
      end
      req_request[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lock_wait[%0d]", k), 64'(mem_request), 64'd0);
      end
      lock = 1'b0;
      @(posedge clk);
      #1;
      chk("unlock_request", 64'(mem_request), 64'd1);
      chk("unlock_address", 64'(mem_address), 64'h0000222);
      serve(2, g);
      chk("unlock_grant", 64'(g), 64'd2);
      req_request = '0;

      // ---- reset during BUSY --------------------------------------------------
      do_reset();
      set_req(2, 1'b0, 27'h0000200, 16'h2222);
      @(posedge clk);
      #1;
      chk("rbusy_request", 64'(mem_request), 64'd1);
      reset = 1'b1;
      req_request = '0;
      @(posedge clk);
      #1;
      chk("rbusy_after_request", 64'(mem_request), 64'd0);
      mem_ack = 1'b1;
      #1;
      chk("rbusy_after_req_ack", 64'(req_ack), 64'd0);
      mem_ack = 1'b0;
      reset   = 1'b0;
      set_req(1, 1'b0, 27'h0000100, 16'h1111);
      set_req(3, 1'b0, 27'h0000300, 16'h3333);
      serve(2, g);
      chk("rbusy_first_grant", 64'(g), 64'd1);
      req_request = '0;

`ifdef MEM_SCHED_STATS_EN
      // ---- grant statistics ---------------------------------------------------
      do_reset();
      set_req(2, 1'b0, 27'h0000200, 16'h2222);
      for (int k = 0; k < 10; k++) begin
         serve(2, g);
         if (k == 9) req_request = '0;
      end
      @(posedge clk);
      #1;
      chk("stat_req0", 64'(stat_grants[0*32 +: 32]), 64'd0);
      chk("stat_req1", 64'(stat_grants[1*32 +: 32]), 64'd0);
      chk("stat_req2", 64'(stat_grants[2*32 +: 32]), 64'd10);
      chk("stat_req3", 64'(stat_grants[3*32 +: 32]), 64'd0);
      stat_clear = 1'b1;
      @(posedge clk);
      #1;
      stat_clear = 1'b0;
      chk("stat_cleared", 64'(stat_grants[2*32 +: 32]), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mem_sched_rr
